pipe_int_ctrl: RTL

Parametrised multi-source interrupt controller for the five-stage pipeline. It replaces the single-input interrupt path with NUM_IRQ edge-detected, maskable, fixed-priority sources. For each accepted interrupt it sequences the entry: freeze fetch, drain the pipeline, push PC, push CCR, load the vector. It tracks in-service state until the return-from-interrupt retires. It sits beside the fetch stage, drives PC freeze and PC load, and handshakes with the memory stage for the two stack pushes.

---
 rtl/pipe_int_ctrl_pkg.sv | 19 +
 rtl/pipe_int_ctrl_if.sv | 43 ++++
 rtl/pipe_int_ctrl_prio_enc.sv | 22 ++
 rtl/pipe_int_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pipe_int_ctrl_pkg.sv
// Shared types for the pipeline interrupt controller: entry-sequence state
// encoding and the interrupt-id width helper.
package pipe_int_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    PUSH_PC,
    PUSH_CCR,
    VECTOR,
    SERVICE
  } state_t;

  // clog2 with a floor of one bit, so a single-source build still has an id port
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_int_ctrl_if.sv
// Signal bundle between the interrupt controller (master) and the
// fetch/memory stages (slave), plus read-only debug taps of internal state.
interface pipe_int_ctrl_if #(
  parameter int NUM_IRQ = 4,
  parameter int ADDR_W  = 32
);
  import pipe_int_pkg::*;

  localparam int ID_W = id_w(NUM_IRQ);

  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               pipe_empty;
  logic               push_ack;
  logic               rti_done;

  // Push handshake: a push request is held high until the memory stage
  // returns a one-cycle push_ack; the request drops on the following cycle.
  logic               fetch_stall;
  logic               push_pc_req;
  logic               push_ccr_req;
  logic               vec_valid;
  logic [ADDR_W-1:0]  vec_addr;
  logic               int_active;
  logic [ID_W-1:0]    int_id;

  state_t             state_dbg;
  logic [NUM_IRQ-1:0] pending_dbg;
  logic [NUM_IRQ-1:0] in_service_dbg;

  modport master (
    input  irq, irq_mask, pipe_empty, push_ack, rti_done,
    output fetch_stall, push_pc_req, push_ccr_req, vec_valid, vec_addr,
           int_active, int_id, state_dbg, pending_dbg, in_service_dbg
  );

  modport slave (
    output irq, irq_mask, pipe_empty, push_ack, rti_done,
    input  fetch_stall, push_pc_req, push_ccr_req, vec_valid, vec_addr,
           int_active, int_id, state_dbg, pending_dbg, in_service_dbg
  );

endinterface

// File: rtl/pipe_int_ctrl_prio_enc.sv
// Lowest-set-bit encoder: index 0 is the highest priority.
module irq_priority_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/pipe_int_ctrl.sv
// Multi-source fixed-priority interrupt controller sequencing pipeline entry
// (drain, push PC, push CCR, vector). Define INT_NEST_EN to allow nesting.
module pipe_int_ctrl
  import pipe_int_pkg::*;
#(
  parameter int              NUM_IRQ    = 4,
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE = '0,
  parameter int              VEC_STRIDE = 2
) (
  input  logic          clk,
  input  logic          reset,
  pipe_int_ctrl_if.master bus
);

  localparam int ID_W = id_w(NUM_IRQ);

  state_t             state;
  state_t             state_nxt;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] in_service;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] id_oh;
  logic [NUM_IRQ-1:0] svc_clr;
  logic [NUM_IRQ-1:0] svc_left;
  logic [ID_W-1:0]    int_id_r;
  logic [ID_W-1:0]    cand_idx;
  logic [ID_W-1:0]    svc_idx;
  logic               cand_valid;
  logic               svc_valid;
  logic               rti_take;
  logic               nest_ok;
  logic               load_id;

  assign rise = bus.irq & ~irq_q;
  assign cand = pending & bus.irq_mask;

  irq_priority_enc #(.N(NUM_IRQ), .W(ID_W)) u_grant_enc (
    .req   (cand),
    .valid (cand_valid),
    .idx   (cand_idx)
  );

  irq_priority_enc #(.N(NUM_IRQ), .W(ID_W)) u_svc_enc (
    .req   (in_service),
    .valid (svc_valid),
    .idx   (svc_idx)
  );

  assign id_oh    = NUM_IRQ'(1) << int_id_r;
  assign rti_take = (state == SERVICE) && bus.rti_done && svc_valid;
  assign svc_clr  = rti_take ? (NUM_IRQ'(1) << svc_idx) : '0;
  assign svc_left = in_service & ~svc_clr;

`ifdef INT_NEST_EN
  // Only a strictly higher priority than everything already in service preempts
  assign nest_ok = cand_valid && svc_valid && (cand_idx < svc_idx);
`else
  assign nest_ok = 1'b0;
`endif

  assign load_id = (state_nxt == DRAIN) && ((state == IDLE) || (state == SERVICE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (cand_valid) state_nxt = DRAIN;
      DRAIN:    if (bus.pipe_empty) state_nxt = PUSH_PC;
      PUSH_PC:  if (bus.push_ack) state_nxt = PUSH_CCR;
      PUSH_CCR: if (bus.push_ack) state_nxt = VECTOR;
      VECTOR:   state_nxt = SERVICE;
      SERVICE: begin
        if (rti_take && (svc_left == '0)) state_nxt = IDLE;
        else if (nest_ok)                 state_nxt = DRAIN;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Pending set wins over the VECTOR-cycle clear of the same bit
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q      <= '0;
      pending    <= '0;
      in_service <= '0;
      int_id_r   <= '0;
    end else begin
      irq_q      <= bus.irq;
      pending    <= (pending & ~((state == VECTOR) ? id_oh : '0)) | rise;
      in_service <= svc_left | ((state == VECTOR) ? id_oh : '0);
      if (load_id) int_id_r <= cand_idx;
    end
  end

  always_comb begin
    bus.fetch_stall  = 1'b0;
    bus.push_pc_req  = 1'b0;
    bus.push_ccr_req = 1'b0;
    bus.vec_valid    = 1'b0;
    case (state)
      DRAIN:    bus.fetch_stall = 1'b1;
      PUSH_PC: begin
        bus.fetch_stall = 1'b1;
        bus.push_pc_req = 1'b1;
      end
      PUSH_CCR: begin
        bus.fetch_stall  = 1'b1;
        bus.push_ccr_req = 1'b1;
      end
      VECTOR: begin
        bus.fetch_stall = 1'b1;
        bus.vec_valid   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.vec_addr       = VEC_BASE + ADDR_W'(int_id_r) * ADDR_W'(VEC_STRIDE);
  assign bus.int_active     = |in_service;
  assign bus.int_id         = int_id_r;
  assign bus.state_dbg      = state;
  assign bus.pending_dbg    = pending;
  assign bus.in_service_dbg = in_service;

endmodule
